sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//  Parametrised single-clock FIFO; successor to the fixed 32-bit fifo1 used
//  between the AXI slave and the SPI engine (TX and RX queues).
//  Adds configurable width/depth, fill level, almost-full/empty thresholds,
//  synchronous flush and sticky overflow/underflow error flags.
//  Output is first-word-fall-through: the head word is on data_o whenever
//  empty_o is low.
// PARAMETERS
//  DATA_W    32         data word width, bits
//  DEPTH     16         number of entries; power of 2, >= 2
//  AFULL_TH  DEPTH-2    almost_full_o asserts when level_o >= AFULL_TH
//  AEMPTY_TH 1          almost_empty_o asserts when level_o <= AEMPTY_TH
//  (derived) ADDR_W = $clog2(DEPTH); level width LVL_W = ADDR_W+1
// PORTS
//  clk_i          in   1       clock; all state changes on rising edge
//  rst_i          in   1       reset, asynchronous, active-high
//  flush_i        in   1       sync flush: empty FIFO, clear error flags
//  data_i         in   DATA_W  write data, sampled when a push is accepted
//  push_i         in   1       write request
//  pull_i         in   1       read request; pops the current head
//  data_o         out  DATA_W  head word (FWFT); 0 while empty_o=1
//  full_o         out  1       level_o == DEPTH
//  empty_o        out  1       level_o == 0
//  almost_full_o  out  1       level_o >= AFULL_TH
//  almost_empty_o out  1       level_o <= AEMPTY_TH
//  level_o        out  LVL_W   current number of stored words, 0..DEPTH
//  ovf_o          out  1       sticky: push attempted while full, not accepted
//  udf_o          out  1       sticky: pull attempted while empty
// BEHAVIOUR
//  Reset (async, rst_i=1): wr/rd pointers=0, level_o=0, empty_o=1, full_o=0,
//   almost_empty_o=1, almost_full_o=0, ovf_o=0, udf_o=0, data_o=0.
//   Memory contents are not reset. Reset mid-operation discards all data.
//  Storage: DEPTH x DATA_W register array; wr_ptr, rd_ptr are ADDR_W bits and
//   wrap DEPTH-1 -> 0 naturally; level_o is a separate LVL_W-bit counter.
//  Accept rules, evaluated each rising edge (flush_i=0):
//   pull_ok = pull_i & ~empty_o
//   push_ok = push_i & (~full_o | pull_ok)   // full + pull frees one slot
//   push_ok: mem[wr_ptr]<=data_i, wr_ptr++.  pull_ok: rd_ptr++.
//   level_o: +1 on push only, -1 on pull only, unchanged on both/neither.
//  Simultaneous push+pull:
//   - empty: pull rejected (udf_o set), push accepted, level 0->1.
//   - full:  both accepted, level stays DEPTH, full_o stays 1, no ovf.
//   - otherwise: both accepted, level unchanged.
//  Errors: push_i & full_o & ~pull_ok -> ovf_o<=1, data dropped, state kept.
//   pull_i & empty_o -> udf_o<=1, pointers unchanged. Flags hold until reset
//   or flush.
//  Flush: flush_i=1 at an edge -> pointers=0, level_o=0, ovf_o=udf_o=0; any
//   push/pull in the same cycle is ignored (flush has priority).
//  Latency: push accepted at edge N -> empty_o=0, data_o=word from cycle N+1
//   (one-cycle write-to-read latency). Pull at edge N -> next word on data_o
//   from cycle N+1. Flags/level are registered level-derived, same cycle.
//  All status outputs are decoded from level_o (registered); data_o is a
//   combinational mux of mem[rd_ptr] gated by ~empty_o.
// TESTING
//  1 Reset: rst_i pulse mid-run with 3 words stored -> immediately level_o=0,
//    empty_o=1, data_o=0, ovf_o=udf_o=0; clean restart afterwards.
//  2 Fill/drain DEPTH=16: push 1..16 -> full_o=1 after 16th, almost_full_o=1
//    at level 14; pull 16 -> data_o sequence 1..16, empty_o=1, no flags.
//  3 Overflow: full, push 0xDEAD -> ovf_o=1, level 16, 0xDEAD never read out;
//    pull on empty -> udf_o=1, level stays 0.
//  4 Simultaneous: full + push 0x55 + pull -> level 16, head advances, 0x55
//    read last; empty + push 0x77 + pull -> level 1, data_o=0x77, udf_o=1.
//  5 Wrap-around: 40 interleaved push/pull of incrementing data at level 5
//    -> output order exact, pointers wrap, level constant 5.
//  6 Flush: level 9, ovf_o=1, flush_i with push_i=1 -> level 0, empty_o=1,
//    ovf_o=0, pushed word discarded.

Source files
------------

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock first-word-fall-through FIFO
//
// Single-clock FIFO with configurable width/depth, fill level, almost-full and
// almost-empty thresholds, synchronous flush and sticky overflow/underflow flags.
// The head word is presented on data_o whenever empty_o is low.
//
// Ports:
//   clk_i          in   1       clock, rising edge
//   rst_i          in   1       asynchronous active-high reset
//   flush_i        in   1       synchronous flush (empties FIFO, clears flags)
//   data_i         in   DATA_W  write data
//   push_i         in   1       write request
//   pull_i         in   1       read request (pops current head)
//   data_o         out  DATA_W  head word, 0 while empty
//   full_o         out  1       level_o == DEPTH
//   empty_o        out  1       level_o == 0
//   almost_full_o  out  1       level_o >= AFULL_TH
//   almost_empty_o out  1       level_o <= AEMPTY_TH
//   level_o        out  LVL_W   stored word count 0..DEPTH
//   ovf_o          out  1       sticky: push rejected while full
//   udf_o          out  1       sticky: pull attempted while empty

module sync_fifo_param #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 1,
  localparam int ADDR_W   = $clog2(DEPTH),
  localparam int LVL_W    = ADDR_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              push_i,
  input  logic              pull_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic [LVL_W-1:0]  level_o,
  output logic              ovf_o,
  output logic              udf_o
);

  localparam logic [LVL_W-1:0] LVL_DEPTH  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_AFULL  = LVL_W'(AFULL_TH);
  localparam logic [LVL_W-1:0] LVL_AEMPTY = LVL_W'(AEMPTY_TH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_ovf;
  logic              r_udf;

  logic w_full;
  logic w_empty;
  logic w_pull_ok;
  logic w_push_ok;

  assign w_full  = (r_level == LVL_DEPTH);
  assign w_empty = (r_level == '0);

  // A pull on a full FIFO frees the slot the simultaneous push will use.
  assign w_pull_ok = pull_i & ~w_empty;
  assign w_push_ok = push_i & (~w_full | w_pull_ok);

  // Storage is deliberately not reset; stale words are masked by the level.
  always_ff @(posedge clk_i) begin
    if (w_push_ok && !flush_i) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_pull_ok) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      case ({w_push_ok, w_pull_ok})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
      if (push_i && !w_push_ok) begin
        r_ovf <= 1'b1;
      end
      if (pull_i && w_empty) begin
        r_udf <= 1'b1;
      end
    end
  end

  assign data_o         = w_empty ? '0 : r_mem[r_rd_ptr];
  assign full_o         = w_full;
  assign empty_o        = w_empty;
  assign almost_full_o  = (r_level >= LVL_AFULL);
  assign almost_empty_o = (r_level <= LVL_AEMPTY);
  assign level_o        = r_level;
  assign ovf_o          = r_ovf;
  assign udf_o          = r_udf;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - scoreboard testbench for sync_fifo_param

module tb_sync_fifo_param;

  localparam int DW  = 32;
  localparam int DEP = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          flush_i;
  logic [DW-1:0] data_i;
  logic          push_i;
  logic          pull_i;
  logic [DW-1:0] data_o;
  logic          full_o;
  logic          empty_o;
  logic          almost_full_o;
  logic          almost_empty_o;
  logic [4:0]    level_o;
  logic          ovf_o;
  logic          udf_o;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] sb[$];
  int            m_level = 0;
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEP)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .data_i(data_i),
    .push_i(push_i), .pull_i(pull_i), .data_o(data_o), .full_o(full_o),
    .empty_o(empty_o), .almost_full_o(almost_full_o),
    .almost_empty_o(almost_empty_o), .level_o(level_o), .ovf_o(ovf_o),
    .udf_o(udf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: whenever the DUT will accept a pull at the next edge, the head
  // word must match the oldest word the stimulus expects to be stored.
  always @(negedge clk_i) begin
    if (!rst_i && !flush_i && pull_i && !empty_o) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got 0x%0h, expected no data at %0t", data_o, $time);
      end else begin
        logic [DW-1:0] exp_w;
        exp_w = sb.pop_front();
        if (data_o !== exp_w) begin
          errors++;
          $display("FAIL pop_data: got 0x%0h, expected 0x%0h at %0t", data_o, exp_w, $time);
        end
      end
    end
  end

  task automatic check_status();
    check("level",    32'(level_o),        32'(m_level));
    check("empty",    32'(empty_o),        32'(m_level == 0));
    check("full",     32'(full_o),         32'(m_level == DEP));
    check("afull",    32'(almost_full_o),  32'(m_level >= DEP - 2));
    check("aempty",   32'(almost_empty_o), 32'(m_level <= 1));
    check("ovf",      32'(ovf_o),          32'(m_ovf));
    check("udf",      32'(udf_o),          32'(m_udf));
    if (m_level == 0) check("data_empty", data_o, 32'h0);
  endtask

  task automatic cyc(input logic p, input logic [DW-1:0] d, input logic q, input logic f);
    logic pok, wok;
    push_i = p; data_i = d; pull_i = q; flush_i = f;
    if (f) begin
      sb.delete();
      m_level = 0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      pok = q && (m_level != 0);
      wok = p && ((m_level != DEP) || pok);
      if (q && m_level == 0) m_udf = 1'b1;
      if (p && !wok) m_ovf = 1'b1;
      if (wok) sb.push_back(d);
      m_level = m_level + int'(wok) - int'(pok);
    end
    @(posedge clk_i); #1;
    push_i = 1'b0; pull_i = 1'b0; flush_i = 1'b0;
    check_status();
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; data_i = '0; push_i = 1'b0; pull_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    check_status();

    // Reset mid-run with three words stored
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'hA0 + i, 1'b0, 1'b0);
    check("pre_rst_level", 32'(level_o), 32'd3);
    #2 rst_i = 1'b1;
    #1;
    sb.delete(); m_level = 0; m_ovf = 1'b0; m_udf = 1'b0;
    check("rst_level", 32'(level_o), 32'd0);
    check("rst_empty", 32'(empty_o), 32'd1);
    check("rst_data",  data_o, 32'h0);
    check("rst_flags", {30'd0, ovf_o, udf_o}, 32'd0);
    @(posedge clk_i); #1 rst_i = 1'b0;
    cyc(1'b1, 32'h1234, 1'b0, 1'b0);
    check("restart_head", data_o, 32'h1234);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Fill and drain
    for (int i = 1; i <= DEP; i++) begin
      cyc(1'b1, 32'(i), 1'b0, 1'b0);
      if (i == 13) check("afull_at13", 32'(almost_full_o), 32'd0);
      if (i == 14) check("afull_at14", 32'(almost_full_o), 32'd1);
    end
    check("full_after16", 32'(full_o), 32'd1);
    check("head_after_fill", data_o, 32'd1);
    for (int i = 1; i <= DEP; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    check("drained_empty", 32'(empty_o), 32'd1);
    check("drained_flags", {30'd0, ovf_o, udf_o}, 32'd0);

    // Overflow then underflow
    for (int i = 1; i <= DEP; i++) cyc(1'b1, 32'h100 + i, 1'b0, 1'b0);
    cyc(1'b1, 32'hDEAD, 1'b0, 1'b0);
    check("ovf_set", 32'(ovf_o), 32'd1);
    check("ovf_level", 32'(level_o), 32'd16);
    for (int i = 1; i <= DEP; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    check("udf_set", 32'(udf_o), 32'd1);
    check("udf_level", 32'(level_o), 32'd0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);

    // Simultaneous push/pull when full and when empty
    for (int i = 1; i <= DEP; i++) cyc(1'b1, 32'h200 + i, 1'b0, 1'b0);
    cyc(1'b1, 32'h55, 1'b1, 1'b0);
    check("sim_full_level", 32'(level_o), 32'd16);
    check("sim_full_head", data_o, 32'h202);
    check("sim_full_noovf", 32'(ovf_o), 32'd0);
    for (int i = 1; i <= DEP; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b1, 32'h77, 1'b1, 1'b0);
    check("sim_empty_level", 32'(level_o), 32'd1);
    check("sim_empty_data", data_o, 32'h77);
    check("sim_empty_udf", 32'(udf_o), 32'd1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);

    // Wrap-around at constant level 5
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h300 + i, 1'b0, 1'b0);
    for (int i = 5; i < 45; i++) begin
      cyc(1'b1, 32'h300 + i, 1'b1, 1'b0);
      if (i == 44) check("wrap_level", 32'(level_o), 32'd5);
    end
    check("wrap_head", data_o, 32'h328);
    for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush with concurrent push: level 9 and ovf set beforehand
    for (int i = 1; i <= DEP; i++) cyc(1'b1, 32'h400 + i, 1'b0, 1'b0);
    cyc(1'b1, 32'hBAD, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    check("preflush_level", 32'(level_o), 32'd9);
    check("preflush_ovf", 32'(ovf_o), 32'd1);
    cyc(1'b1, 32'hF00D, 1'b0, 1'b1);
    check("flush_level", 32'(level_o), 32'd0);
    check("flush_empty", 32'(empty_o), 32'd1);
    check("flush_ovf", 32'(ovf_o), 32'd0);
    cyc(1'b1, 32'h5A5A, 1'b0, 1'b0);
    check("postflush_head", data_o, 32'h5A5A);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
